tick_timer: RTL and testbench
=============================

# tick_timer

Minutes:seconds BCD stopwatch that consumes the slow square wave produced by the clock-divider stage and turns it into a counted, displayable time value. It sits directly downstream of the divider: the divider output is treated as data, not as a clock. It is synchronised into the system clock domain and edge-detected into single-cycle ticks. Ticks are prescaled and drive a four-digit BCD counter under start/stop/clear control, feeding the seven-segment display stage.

## Interface
- PRESCALE, default 95: divider ticks per one-second count; legal range 1..255.
- clock  in  1  system clock; every register in the block is clocked by it.
- rst  in  1  reset, synchronous and active-high.
- clk_in  in  1  divider output (clk_out of the divider stage); asynchronous to clock, slow square wave.
- start  in  1  one-cycle request to run.
- stop  in  1  one-cycle request to pause.
- clear  in  1  one-cycle request to return to zero and idle.
- sec_ones  out  4  BCD seconds units, 0..9.
- sec_tens  out  4  BCD seconds tens, 0..5.
- min_ones  out  4  BCD minutes units, 0..9.
- min_tens  out  4  BCD minutes tens, 0..5.
- running  out  1  high while state is RUN.
- tick  out  1  one-cycle pulse per rising edge of clk_in, independent of state.
- wrap  out  1  one-cycle pulse when 59:59 advances to 00:00.

## Operation
- Synchroniser: two flops on clk_in (s1, s2), then a history flop s3. The edge condition is s2 & ~s3. tick is the registered version of that condition.
- Prescaler: 8-bit pcount, meaningful 0..PRESCALE-1.
  - A tick in RUN increments pcount.
  - When a tick arrives with pcount == PRESCALE-1, pcount goes to 0 and the counter advances one second.
  - Ticks outside RUN are ignored and pcount holds.
- States (2-bit encoding):
  - IDLE: after reset or clear. Digits 00:00, pcount 0.
  - RUN: counting.
  - PAUSE: frozen. Digits and pcount hold.
- Transitions:
  - IDLE -start-> RUN.
  - PAUSE -start-> RUN.
  - RUN -stop-> PAUSE.
  - Any state -clear-> IDLE.
  - start in RUN, and stop in IDLE or PAUSE, are no-ops.
- Priority within one cycle: rst > clear > stop > start.
  - clear in the same cycle as an advance: clear wins, digits become 00:00 and wrap stays 0.
  - start and stop together in RUN gives PAUSE. In IDLE or PAUSE it is a no-op.
- BCD advance (carry ripples within a single cycle):
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - min_tens 5→0 pulses wrap.
  - Digits never hold values outside their ranges.
- Resume from PAUSE continues from the held pcount. No partial second is lost or added.

## Timing
- Reset values: all digits 0, running 0, tick 0, wrap 0, state IDLE, pcount 0, s1/s2/s3 0.
- tick latency:
  - clk_in first sampled high at edge n: s1=1 after n, s2=1 after n+1.
  - tick is high for exactly the cycle after edge n+2.
  - One tick per clk_in rising edge. No tick on falling edges.
- Digit and wrap latency: update at the edge after the tick that completes the prescale, i.e. one cycle after tick is high.
- running is registered: high the cycle after the edge that samples start, low the cycle after the edge that samples stop or clear.
- A start landing on the same edge as a tick-cycle does not count that tick. Counting begins with the next tick.
- rst mid-operation: at the next clock edge all state returns to reset values, including the synchroniser. A clk_in edge that is in flight during rst is dropped.
- PRESCALE=1: every tick advances the counter.

## Structure
- Shared package tick_timer_pkg holds:
  - state encoding (IDLE=2'b00, RUN=2'b01, PAUSE=2'b10);
  - digit limits SEC_TENS_MAX=5, MIN_TENS_MAX=5, ONES_MAX=9;
  - the 4-bit BCD digit type.
- One sub-module, edge_sync: the two-flop synchroniser, history flop and registered rising-edge pulse. It is reusable for button inputs elsewhere in the design.
- Top level holds the FSM, prescaler and BCD chain.

## Test plan
- Reset: assert rst for 3 cycles with clk_in toggling → all outputs 0, no tick during or in the 2 cycles after rst.
- Tick latency: raise clk_in before edge 10 → tick high only in the cycle after edge 12. A falling edge of clk_in produces no tick.
- Counting: PRESCALE=2, start, then 20 ticks → 00:10 exactly, running=1.
- Pause/resume: PRESCALE=4. Start, 2 ticks, stop, 5 ticks, start, 2 ticks → display 00:01. No advance during pause.
- Wrap: preload to 59:59 via counting with PRESCALE=1, then 1 tick → 00:00 and wrap high for exactly one cycle.
- Priority: clear in the same cycle as the advancing tick-cycle → 00:00, wrap 0, IDLE. start+stop together in RUN → PAUSE.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// rtl/tick_timer_pkg.sv - shared types, state encoding and digit limits for tick_timer
package tick_timer_pkg;

  // 4-bit BCD digit
  typedef logic [3:0] bcd_t;

  // stopwatch control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // highest legal value of each digit position
  localparam bcd_t ONES_MAX     = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

  // a digit at (or, defensively, beyond) its limit rolls to zero on advance
  function automatic logic bcd_at_max(input bcd_t d, input bcd_t max);
    return (d >= max);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchroniser with registered rising-edge pulse
module edge_sync (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  // bring din into the clock domain, keep one sample of history, pulse on 0->1
  always_ff @(posedge clock) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - mm:ss BCD stopwatch driven by divider ticks
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int PRESCALE = 95
) (
  input  logic clock,
  input  logic rst,
  input  logic clk_in,
  input  logic start,
  input  logic stop,
  input  logic clear,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic running,
  output logic tick,
  output logic wrap
);

  localparam logic [7:0] PCOUNT_LAST = 8'(PRESCALE - 1);

  state_t     state;
  logic [7:0] pcount;
  logic       tick_pulse;

  bcd_t sec_ones_nx;
  bcd_t sec_tens_nx;
  bcd_t min_ones_nx;
  bcd_t min_tens_nx;
  logic wrap_nx;
  logic advance;

  // the divider output is data here; it only ever reaches us as a one-cycle tick
  edge_sync u_edge_sync (
    .clock (clock),
    .rst   (rst),
    .din   (clk_in),
    .pulse (tick_pulse)
  );

  assign tick = tick_pulse;

  // a tick completes the prescale only while running; the state seen is the pre-edge one
  assign advance = (state == ST_RUN) && tick_pulse && (pcount == PCOUNT_LAST);

  // one-second increment with the carry rippling through all four digits
  always_comb begin
    sec_ones_nx = sec_ones;
    sec_tens_nx = sec_tens;
    min_ones_nx = min_ones;
    min_tens_nx = min_tens;
    wrap_nx     = 1'b0;
    if (bcd_at_max(sec_ones, ONES_MAX)) begin
      sec_ones_nx = 4'd0;
      if (bcd_at_max(sec_tens, SEC_TENS_MAX)) begin
        sec_tens_nx = 4'd0;
        if (bcd_at_max(min_ones, ONES_MAX)) begin
          min_ones_nx = 4'd0;
          if (bcd_at_max(min_tens, MIN_TENS_MAX)) begin
            min_tens_nx = 4'd0;
            wrap_nx     = 1'b1;
          end else begin
            min_tens_nx = min_tens + 4'd1;
          end
        end else begin
          min_ones_nx = min_ones + 4'd1;
        end
      end else begin
        sec_tens_nx = sec_tens + 4'd1;
      end
    end else begin
      sec_ones_nx = sec_ones + 4'd1;
    end
  end

  // control FSM, prescaler and digit registers; clear overrides everything but rst
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      pcount   <= 8'd0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        state    <= ST_IDLE;
        running  <= 1'b0;
        pcount   <= 8'd0;
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        min_tens <= 4'd0;
      end else begin
        if (state == ST_RUN && tick_pulse) begin
          if (advance) begin
            pcount   <= 8'd0;
            sec_ones <= sec_ones_nx;
            sec_tens <= sec_tens_nx;
            min_ones <= min_ones_nx;
            min_tens <= min_tens_nx;
            wrap     <= wrap_nx;
          end else begin
            pcount <= pcount + 8'd1;
          end
        end
        case (state)
          ST_IDLE, ST_PAUSE: begin
            // stop outranks start, so start+stop together leaves us parked
            if (start && !stop) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - self-checking bench for tick_timer at PRESCALE 1, 2 and 4
module tb_tick_timer;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       clk_in = 1'b0;
  logic       start [3];
  logic       stop  [3];
  logic       clear [3];
  logic [3:0] so [3];
  logic [3:0] st [3];
  logic [3:0] mo [3];
  logic [3:0] mt [3];
  logic       running [3];
  logic       tick [3];
  logic       wrap [3];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: elapsed seconds as a plain integer, ticks within the current second
  int m_secs [3];
  int m_pre  [3];
  bit m_run  [3];
  bit m_wrap [3];
  bit m_tick;
  bit hist [$];

  initial forever #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tick_timer #(.PRESCALE((g == 0) ? 1 : (g == 1) ? 2 : 4)) dut (
      .clock    (clock),
      .rst      (rst),
      .clk_in   (clk_in),
      .start    (start[g]),
      .stop     (stop[g]),
      .clear    (clear[g]),
      .sec_ones (so[g]),
      .sec_tens (st[g]),
      .min_ones (mo[g]),
      .min_tens (mt[g]),
      .running  (running[g]),
      .tick     (tick[g]),
      .wrap     (wrap[g])
    );
  end

  function automatic int ps(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  function automatic logic [15:0] bcd(input int s);
    int m;
    int sec;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  function automatic logic [15:0] disp(input int i);
    return {mt[i], mo[i], st[i], so[i]};
  endfunction

  task automatic check(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, idx, obs, exp, $time);
  endtask

  // advance the model across one clock edge using the inputs held before the edge
  task automatic model_edge();
    bit tprev;
    tprev = m_tick;
    if (rst) begin
      hist = '{0, 0, 0, 0};
      m_tick = 0;
      for (int i = 0; i < 3; i++) begin
        m_secs[i] = 0; m_pre[i] = 0; m_run[i] = 0; m_wrap[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_wrap[i] = 0;
        if (clear[i]) begin
          m_run[i] = 0; m_secs[i] = 0; m_pre[i] = 0;
        end else begin
          if (m_run[i] && tprev) begin
            m_pre[i]++;
            if (m_pre[i] == ps(i)) begin
              m_pre[i] = 0;
              m_secs[i]++;
              if (m_secs[i] == 3600) begin
                m_secs[i] = 0;
                m_wrap[i] = 1;
              end
            end
          end
          if (m_run[i] && stop[i]) m_run[i] = 0;
          else if (!m_run[i] && start[i] && !stop[i]) m_run[i] = 1;
        end
      end
      // a tick appears two edges after clk_in is first seen high following a low sample
      hist.push_front(clk_in);
      void'(hist.pop_back());
      m_tick = hist[2] && !hist[3];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check("digits", i, disp(i), bcd(m_secs[i]));
      check("running", i, 16'(running[i]), 16'(m_run[i]));
      check("wrap", i, 16'(wrap[i]), 16'(m_wrap[i]));
      check("tick", i, 16'(tick[i]), 16'(m_tick));
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_ctl(input bit sa, input bit sp, input bit cl);
    for (int i = 0; i < 3; i++) begin
      start[i] = sa; stop[i] = sp; clear[i] = cl;
    end
  endtask

  task automatic gen_tick();
    clk_in = 1'b1; step(); step();
    clk_in = 1'b0; step(); step();
  endtask

  initial begin
    int wc;
    hist = '{0, 0, 0, 0};
    m_tick = 0;
    for (int i = 0; i < 3; i++) begin
      m_secs[i] = 0; m_pre[i] = 0; m_run[i] = 0; m_wrap[i] = 0;
    end
    set_ctl(0, 0, 0);

    // reset held for three cycles with clk_in toggling, then two quiet cycles
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clk_in = ~clk_in;
      step();
      check("rst_tick", 0, 16'(tick[0]), 16'd0);
      check("rst_disp", 0, disp(0), 16'h0000);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clk_in = ~clk_in;
      step();
      check("post_rst_tick", 0, 16'(tick[0]), 16'd0);
    end
    clk_in = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // tick latency: high only in the cycle after the third edge; none on the fall
    clk_in = 1'b1;
    step(); check("lat_n", 0, 16'(tick[0]), 16'd0);
    step(); check("lat_n1", 0, 16'(tick[0]), 16'd0);
    step(); check("lat_n2", 0, 16'(tick[0]), 16'd1);
    step(); check("lat_n3", 0, 16'(tick[0]), 16'd0);
    step();
    clk_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); check("fall_tick", 0, 16'(tick[0]), 16'd0);
    end

    // counting: 20 ticks
    set_ctl(1, 0, 0); step(); set_ctl(0, 0, 0);
    for (int k = 0; k < 20; k++) gen_tick();
    check("count_p2", 1, disp(1), 16'h0010);
    check("count_p1", 0, disp(0), 16'h0020);
    check("count_p4", 2, disp(2), 16'h0005);
    check("count_run", 1, 16'(running[1]), 16'd1);

    // pause/resume keeps the partial second
    set_ctl(0, 0, 1); step();
    set_ctl(1, 0, 0); step(); set_ctl(0, 0, 0);
    gen_tick(); gen_tick();
    set_ctl(0, 1, 0); step(); set_ctl(0, 0, 0);
    for (int k = 0; k < 5; k++) gen_tick();
    check("pause_hold", 2, disp(2), 16'h0000);
    set_ctl(1, 0, 0); step(); set_ctl(0, 0, 0);
    gen_tick(); gen_tick();
    check("resume_p4", 2, disp(2), 16'h0001);
    check("resume_p2", 1, disp(1), 16'h0002);

    // count up to 59:59 then wrap
    set_ctl(0, 0, 1); step();
    set_ctl(1, 0, 0); step(); set_ctl(0, 0, 0);
    for (int k = 0; k < 3599; k++) gen_tick();
    check("pre_wrap", 0, disp(0), 16'h5959);
    check("pre_wrap_p2", 1, disp(1), 16'h2959);
    check("pre_wrap_p4", 2, disp(2), 16'h1459);
    wc = 0;
    clk_in = 1'b1;
    step(); wc += int'(wrap[0]);
    step(); wc += int'(wrap[0]);
    clk_in = 1'b0;
    step(); wc += int'(wrap[0]);
    check("wrap_edge", 0, 16'(wrap[0]), 16'd0);
    step(); wc += int'(wrap[0]);
    check("wrap_now", 0, 16'(wrap[0]), 16'd1);
    step(); wc += int'(wrap[0]);
    check("wrap_once", 0, 16'(wc), 16'd1);
    check("post_wrap", 0, disp(0), 16'h0000);
    check("post_wrap_p2", 1, disp(1), 16'h3000);
    check("post_wrap_p4", 2, disp(2), 16'h1500);

    // clear on the advancing edge wins
    clk_in = 1'b1; step(); step(); step();
    clear[0] = 1'b1; step(); clear[0] = 1'b0;
    check("clr_disp", 0, disp(0), 16'h0000);
    check("clr_wrap", 0, 16'(wrap[0]), 16'd0);
    check("clr_run", 0, 16'(running[0]), 16'd0);
    clk_in = 1'b0; step(); step();

    // start and stop together: RUN -> PAUSE, IDLE stays put
    set_ctl(0, 0, 0); start[0] = 1'b1; step();
    check("ss_run", 0, 16'(running[0]), 16'd1);
    start[0] = 1'b1; stop[0] = 1'b1; step();
    check("ss_pause", 0, 16'(running[0]), 16'd0);
    step();
    check("ss_noop", 0, 16'(running[0]), 16'd0);
    set_ctl(0, 0, 0); step();

    // random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) clk_in = ~clk_in;
      for (int i = 0; i < 3; i++) begin
        clear[i] = ($urandom_range(0, 149) == 0);
        stop[i]  = ($urandom_range(0, 39) == 0);
        start[i] = ($urandom_range(0, 19) == 0);
      end
      step();
    end
    rst = 1'b0;
    set_ctl(0, 0, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
